ss_regs_seq: RTL



---
 rtl/ss_regs_pkg.sv | 36 +++
 rtl/ss_regs_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ss_regs_pkg.sv
// Shared definitions for the save-state shadow-register sequencer: state
// encoding, register count, shadow bank and the fixed walk order of the window.
package ss_regs_pkg;

  localparam int         SS_NUM_REGS = 30;
  localparam int         SS_IDX_W    = $clog2(SS_NUM_REGS);
  localparam logic [7:0] SS_BANK     = 8'hC0;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    RD_PUSH,
    WR_PULL,
    WR_STROBE,
    FIN
  } ss_state_e;

  // Walk order is part of the saved image format; changing it breaks old images.
  localparam logic [15:0] SS_ADDR_TABLE [SS_NUM_REGS] = '{
    16'h4300, 16'h4301, 16'h4302, 16'h4303, 16'h4304, 16'h4305, 16'h4306,
    16'h4200, 16'h4202, 16'h4203, 16'h4204, 16'h4205, 16'h4206, 16'h4207,
    16'h4208, 16'h4209, 16'h420A, 16'h420B, 16'h420C, 16'h420D,
    16'h2100,
    16'h21F0, 16'h21F1, 16'h21F2,
    16'h2181, 16'h2182, 16'h2183,
    16'h420F,
    16'h2180, 16'h2184
  };

  function automatic logic [15:0] ss_addr(input logic [SS_IDX_W-1:0] idx);
    ss_addr = 16'h0000;
    if (int'(idx) < SS_NUM_REGS) ss_addr = SS_ADDR_TABLE[idx];
  endfunction

endpackage

// File: rtl/ss_regs_seq.sv
// Save/restore sequencer for the shadow-register window: reads each register
// out onto a byte stream, or writes a byte stream back. SS_REGS_SEQ_CHECKSUM_EN
// appends/verifies an XOR checksum beat.
module ss_regs_seq
  import ss_regs_pkg::*;
#(
  parameter int         NUM_REGS = SS_NUM_REGS,
  parameter logic [7:0] BANK     = SS_BANK
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_save,
  input  logic        start_restore,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [23:0] ss_ca,
  output logic        ss_reg_sel,
  output logic        ss_rd_ce,
  output logic        ss_wr_ce,
  output logic [7:0]  ss_wdata,
  input  logic [7:0]  ss_rdata,
  input  logic        ss_oe,
  output logic [7:0]  sv_data,
  output logic        sv_valid,
  input  logic        sv_ready,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready
);

  localparam int               IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  ss_state_e        state;
  logic [IDX_W-1:0] idx;
  logic             push_last;

`ifdef SS_REGS_SEQ_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_beat;

  // With the checksum, the pass ends on the extra beat rather than the last register.
  assign push_last = csum_beat;
`else
  assign push_last = (idx == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ss_ca      <= '0;
      ss_reg_sel <= 1'b0;
      ss_rd_ce   <= 1'b0;
      ss_wr_ce   <= 1'b0;
      ss_wdata   <= '0;
      sv_data    <= '0;
      sv_valid   <= 1'b0;
      ld_ready   <= 1'b0;
`ifdef SS_REGS_SEQ_CHECKSUM_EN
      csum       <= '0;
      csum_beat  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge state;
      // strobes default low here and are raised only on the edge entering their state.
      ss_rd_ce <= 1'b0;
      ss_wr_ce <= 1'b0;
      done     <= 1'b0;

      if (abort) begin
        state      <= IDLE;
        idx        <= '0;
        busy       <= 1'b0;
        ss_reg_sel <= 1'b0;
        sv_valid   <= 1'b0;
        ld_ready   <= 1'b0;
`ifdef SS_REGS_SEQ_CHECKSUM_EN
        csum_beat  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start_save) begin
              state      <= RD_ADDR;
              busy       <= 1'b1;
              err        <= 1'b0;
              ss_ca      <= {BANK, ss_addr(idx)};
              ss_reg_sel <= 1'b1;
              ss_rd_ce   <= 1'b1;
`ifdef SS_REGS_SEQ_CHECKSUM_EN
              csum       <= '0;
              csum_beat  <= 1'b0;
`endif
            end else if (start_restore) begin
              state    <= WR_PULL;
              busy     <= 1'b1;
              err      <= 1'b0;
              ld_ready <= 1'b1;
`ifdef SS_REGS_SEQ_CHECKSUM_EN
              csum      <= '0;
              csum_beat <= 1'b0;
`endif
            end
          end

          RD_ADDR: state <= RD_WAIT;

          // Shadow data is registered, so it is valid only at the end of this cycle.
          RD_WAIT: begin
            state      <= RD_PUSH;
            ss_reg_sel <= 1'b0;
            sv_valid   <= 1'b1;
            if (ss_oe) begin
              sv_data <= ss_rdata;
            end else begin
              sv_data <= 8'h00;
              err     <= 1'b1;
            end
          end

          RD_PUSH: begin
            if (sv_ready) begin
              sv_valid <= 1'b0;
`ifdef SS_REGS_SEQ_CHECKSUM_EN
              csum <= csum ^ sv_data;
`endif
              if (push_last) begin
                state <= FIN;
                done  <= 1'b1;
              end
`ifdef SS_REGS_SEQ_CHECKSUM_EN
              else if (idx == LAST_IDX) begin
                sv_valid  <= 1'b1;
                sv_data   <= csum ^ sv_data;
                csum_beat <= 1'b1;
              end
`endif
              else begin
                idx        <= idx + 1'b1;
                state      <= RD_ADDR;
                ss_ca      <= {BANK, ss_addr(idx + 1'b1)};
                ss_reg_sel <= 1'b1;
                ss_rd_ce   <= 1'b1;
              end
            end
          end

          WR_PULL: begin
            if (ld_valid) begin
              ld_ready <= 1'b0;
`ifdef SS_REGS_SEQ_CHECKSUM_EN
              csum <= csum ^ ld_data;
              if (csum_beat) begin
                if (ld_data != csum) err <= 1'b1;
                state <= FIN;
                done  <= 1'b1;
              end else
`endif
              begin
                ss_wdata   <= ld_data;
                state      <= WR_STROBE;
                ss_ca      <= {BANK, ss_addr(idx)};
                ss_reg_sel <= 1'b1;
                ss_wr_ce   <= 1'b1;
              end
            end
          end

          WR_STROBE: begin
            ss_reg_sel <= 1'b0;
            if (idx != LAST_IDX) begin
              idx      <= idx + 1'b1;
              state    <= WR_PULL;
              ld_ready <= 1'b1;
            end else begin
`ifdef SS_REGS_SEQ_CHECKSUM_EN
              csum_beat <= 1'b1;
              state     <= WR_PULL;
              ld_ready  <= 1'b1;
`else
              state <= FIN;
              done  <= 1'b1;
`endif
            end
          end

          FIN: begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
`ifdef SS_REGS_SEQ_CHECKSUM_EN
            csum_beat <= 1'b0;
`endif
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
